neuron_grid_sequencer: RTL and testbench

Control FSM for the 256-neuron × 256-axon grid datapath in each RANC core. On every `tick` it steps the datapath through all neurons and, for each neuron, through all axons, asserting the datapath strobes in the required order. It holds the potential write-back while the local router buffer is full, and defers ticks while the parameter loader owns the CSRAM. It sits between the core's tick/scheduler logic and the grid datapath, and is the only driver of the datapath sequencing strobes.

---
 rtl/ranc_grid_pkg.sv | 27 ++
 rtl/wrap_counter.sv | 28 ++
 rtl/neuron_grid_sequencer.sv | 135 +++++++++++++
 tb/tb_neuron_grid_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ranc_grid_pkg.sv
// Shared types and sizing for the RANC grid sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ranc_grid_pkg;

    localparam int DEF_NUM_AXONS   = 256;
    localparam int DEF_NUM_NEURONS = 256;

    // A one-entry loop still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_AXON_W   = cnt_width(DEF_NUM_AXONS);
    localparam int DEF_NEURON_W = cnt_width(DEF_NUM_NEURONS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_NEW,
        ST_SPIKE,
        ST_HOLD,
        ST_UPDATE,
        ST_DONE
    } grid_seq_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Index counter with synchronous clear, increment and wrap at MAX_VAL.
// Latency: count changes on the edge after clr/inc; last is combinational from count.
// Backpressure: none; holds value when neither clr nor inc is asserted.
module wrap_counter #(
    parameter int MAX_VAL = 255,
    parameter int W       = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         last
);

    assign last = (cnt == W'(MAX_VAL));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/neuron_grid_sequencer.sv
// Steps the neuron/axon grid datapath through one full timestep per tick.
// Latency: tick -> INIT next cycle; tick_done 2 + N*(A+2) + hold cycles after tick.
// Backpressure: write-back waits in HOLD while local_buffers_full; starts wait on cfg_busy.
module neuron_grid_sequencer
    import ranc_grid_pkg::*;
#(
    parameter int NUM_AXONS   = DEF_NUM_AXONS,
    parameter int NUM_NEURONS = DEF_NUM_NEURONS
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 tick,
    input  logic                                 cfg_busy,
    input  logic                                 local_buffers_full,
    input  logic                                 overrun_clr,
    output logic                                 initial_axon_num,
    output logic                                 inc_axon_num,
    output logic                                 initial_neuron_num,
    output logic                                 inc_neuron_num,
    output logic                                 new_neuron,
    output logic                                 process_spike,
    output logic                                 update_potential,
    output logic [cnt_width(NUM_AXONS)-1:0]      axon_idx,
    output logic [cnt_width(NUM_NEURONS)-1:0]    neuron_idx,
    output logic                                 busy,
    output logic                                 tick_done,
    output logic                                 overrun
);

    grid_seq_state_t state, state_nxt;
    logic            pending;
    logic            start;
    logic            axon_last;
    logic            neuron_last;

    assign start = (state == ST_IDLE) && (tick || pending) && !cfg_busy;
    assign busy  = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Any tick that cannot start immediately is remembered once; a second one is an overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (start) begin
                pending <= 1'b0;
            end else if (tick) begin
                pending <= 1'b1;
            end
            if (tick && pending) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt          = state;
        initial_axon_num   = 1'b0;
        inc_axon_num       = 1'b0;
        initial_neuron_num = 1'b0;
        inc_neuron_num     = 1'b0;
        new_neuron         = 1'b0;
        process_spike      = 1'b0;
        update_potential   = 1'b0;
        tick_done          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_INIT;
            end
            ST_INIT: begin
                initial_axon_num   = 1'b1;
                initial_neuron_num = 1'b1;
                state_nxt          = ST_NEW;
            end
            ST_NEW: begin
                new_neuron = 1'b1;
                state_nxt  = ST_SPIKE;
            end
            ST_SPIKE: begin
                process_spike = 1'b1;
                inc_axon_num  = 1'b1;
                if (axon_last) state_nxt = local_buffers_full ? ST_HOLD : ST_UPDATE;
            end
            ST_HOLD: begin
                if (!local_buffers_full) state_nxt = ST_UPDATE;
            end
            ST_UPDATE: begin
                update_potential = 1'b1;
                inc_neuron_num   = 1'b1;
                initial_axon_num = 1'b1;
                state_nxt        = neuron_last ? ST_DONE : ST_NEW;
            end
            ST_DONE: begin
                tick_done = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    wrap_counter #(
        .MAX_VAL (NUM_AXONS - 1),
        .W       (cnt_width(NUM_AXONS))
    ) u_axon_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (initial_axon_num),
        .inc     (inc_axon_num),
        .cnt     (axon_idx),
        .last    (axon_last)
    );

    wrap_counter #(
        .MAX_VAL (NUM_NEURONS - 1),
        .W       (cnt_width(NUM_NEURONS))
    ) u_neuron_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (initial_neuron_num),
        .inc     (inc_neuron_num),
        .cnt     (neuron_idx),
        .last    (neuron_last)
    );

endmodule

// File: tb/tb_neuron_grid_sequencer.sv
// Bench for neuron_grid_sequencer: queue-based run model checked every cycle, plus directed literals.
module tb_neuron_grid_sequencer;

    localparam int A = 4;
    localparam int N = 3;

    // {ini_ax, inc_ax, ini_n, inc_n, new, spike, upd, busy, done}
    localparam logic [8:0] V_IDLE  = 9'b000000000;
    localparam logic [8:0] V_INIT  = 9'b101000010;
    localparam logic [8:0] V_NEW   = 9'b000010010;
    localparam logic [8:0] V_SPIKE = 9'b010001010;
    localparam logic [8:0] V_HOLD  = 9'b000000010;
    localparam logic [8:0] V_UPD   = 9'b100100110;
    localparam logic [8:0] V_DONE  = 9'b000000011;

    typedef struct packed {
        logic [8:0] s;
        logic [1:0] ax;
        logic [1:0] nr;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tick = 1'b0, cfg_busy = 1'b0, lbf = 1'b0, overrun_clr = 1'b0;
    logic initial_axon_num, inc_axon_num, initial_neuron_num, inc_neuron_num;
    logic new_neuron, process_spike, update_potential, busy, tick_done, overrun;
    logic [1:0] axon_idx, neuron_idx;
    logic [8:0] dut_vec;

    logic d_tick = 1'b0;
    logic d_ini_ax, d_inc_ax, d_ini_n, d_inc_n, d_new, d_spike, d_upd, d_busy, d_done, d_ovr;
    logic [7:0] d_axon_idx, d_neuron_idx;

    always #5 clk = ~clk;

    neuron_grid_sequencer #(.NUM_AXONS(A), .NUM_NEURONS(N)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .cfg_busy(cfg_busy),
        .local_buffers_full(lbf), .overrun_clr(overrun_clr),
        .initial_axon_num(initial_axon_num), .inc_axon_num(inc_axon_num),
        .initial_neuron_num(initial_neuron_num), .inc_neuron_num(inc_neuron_num),
        .new_neuron(new_neuron), .process_spike(process_spike),
        .update_potential(update_potential), .axon_idx(axon_idx),
        .neuron_idx(neuron_idx), .busy(busy), .tick_done(tick_done), .overrun(overrun)
    );

    neuron_grid_sequencer dut_def (
        .clk(clk), .reset_n(reset_n), .tick(d_tick), .cfg_busy(1'b0),
        .local_buffers_full(1'b0), .overrun_clr(1'b0),
        .initial_axon_num(d_ini_ax), .inc_axon_num(d_inc_ax),
        .initial_neuron_num(d_ini_n), .inc_neuron_num(d_inc_n),
        .new_neuron(d_new), .process_spike(d_spike),
        .update_potential(d_upd), .axon_idx(d_axon_idx),
        .neuron_idx(d_neuron_idx), .busy(d_busy), .tick_done(d_done), .overrun(d_ovr)
    );

    assign dut_vec = {initial_axon_num, inc_axon_num, initial_neuron_num, inc_neuron_num,
                      new_neuron, process_spike, update_potential, busy, tick_done};

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Run model: a run is a precomputed queue of output vectors; HOLD is inserted
    // in front of any UPDATE while the buffer-full input is high.
    ev_t  cur;
    ev_t  q[$];
    logic m_pend, m_ovr, m_start;

    initial begin
        cur = '0; m_pend = 1'b0; m_ovr = 1'b0; m_start = 1'b0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                q.delete();
                cur = '0; m_pend = 1'b0; m_ovr = 1'b0;
            end else begin
                m_start = (cur.s == V_IDLE) && (tick || m_pend) && !cfg_busy;
                if (tick && m_pend) m_ovr = 1'b1;
                else if (overrun_clr) m_ovr = 1'b0;
                if (m_start) m_pend = 1'b0;
                else if (tick) m_pend = 1'b1;
                if (q.size() > 0 && q[0].s == V_UPD && lbf) begin
                    cur = '{V_HOLD, 2'd0, q[0].nr};
                end else if (q.size() > 0) begin
                    cur = q.pop_front();
                end else if (m_start) begin
                    cur = '{V_INIT, 2'd0, 2'd0};
                    for (int n = 0; n < N; n++) begin
                        q.push_back('{V_NEW, 2'd0, 2'(n)});
                        for (int j = 0; j < A; j++) q.push_back('{V_SPIKE, 2'(j), 2'(n)});
                        q.push_back('{V_UPD, 2'd0, 2'(n)});
                    end
                    q.push_back('{V_DONE, 2'd0, 2'd0});
                end else begin
                    cur = '0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("strobes", 32'(dut_vec), 32'(cur.s));
            check("axon_idx", 32'(axon_idx), 32'(cur.ax));
            check("neuron_idx", 32'(neuron_idx), 32'(cur.nr));
            check("overrun", 32'(overrun), 32'(m_ovr));
        end
    end

    int   done1, done2, spikes, upds;
    logic busy_at [64];
    logic init_at [64];
    logic ov_at   [64];
    logic upd_at  [64];

    task automatic run_tick(input int ncyc, input int cfg_drop, input int st_s, input int st_len,
                            input int t2, input int t3, input int clr_c, input int rst_c);
        done1 = -1; done2 = -1; spikes = 0; upds = 0;
        @(negedge clk);
        tick = 1'b1;
        cfg_busy = (cfg_drop > 0);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            tick        = (c == t2) || (c == t3);
            cfg_busy    = (c < cfg_drop);
            lbf         = (c >= st_s) && (c < st_s + st_len);
            overrun_clr = (c == clr_c);
            busy_at[c] = busy;
            init_at[c] = initial_neuron_num;
            ov_at[c]   = overrun;
            upd_at[c]  = update_potential;
            if (process_spike) spikes++;
            if (update_potential) upds++;
            if (tick_done) begin
                if (done1 < 0) done1 = c;
                else done2 = c;
            end
            if (c == rst_c) begin
                #2 reset_n = 1'b0;
                #1;
                check("rst_strobes", 32'(dut_vec), 32'd0);
                check("rst_axon", 32'(axon_idx), 32'd0);
                check("rst_neuron", 32'(neuron_idx), 32'd0);
            end
            if (c == rst_c + 1) begin
                #2 reset_n = 1'b1;
            end
        end
        tick = 1'b0; cfg_busy = 1'b0; lbf = 1'b0; overrun_clr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    int cnt;

    initial begin
        repeat (2) @(negedge clk);
        check("reset_vec", 32'(dut_vec), 32'd0);
        check("reset_ovr", 32'(overrun), 32'd0);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // basic run
        run_tick(24, 0, -1, 0, -1, -1, -1, -1);
        check("basic_done", done1, 20);
        check("basic_single", done2, -1);
        check("basic_spikes", spikes, 12);
        check("basic_updates", upds, 3);
        check("basic_init_c1", 32'(init_at[1]), 32'd1);

        // buffer stall across neuron 1 write-back
        run_tick(28, 0, 12, 5, -1, -1, -1, -1);
        check("stall_done", done1, 25);
        check("stall_upd_orig", 32'(upd_at[13]), 32'd0);
        check("stall_upd_late", 32'(upd_at[18]), 32'd1);
        check("stall_updates", upds, 3);

        // config block
        run_tick(30, 7, -1, 0, -1, -1, -1, -1);
        check("cfg_wait_c7", 32'(busy_at[7]), 32'd0);
        check("cfg_init_c8", 32'(init_at[8]), 32'd1);
        check("cfg_done", done1, 27);

        // back-to-back ticks with overrun
        run_tick(45, 0, -1, 0, 5, 8, 10, -1);
        check("b2b_done1", done1, 20);
        check("b2b_gap_idle", 32'(busy_at[21]), 32'd0);
        check("b2b_init2", 32'(init_at[22]), 32'd1);
        check("b2b_done2", done2, 41);
        check("b2b_ovr_set", 32'(ov_at[9]), 32'd1);
        check("b2b_ovr_clr", 32'(ov_at[11]), 32'd0);

        // reset mid-run during neuron 2 SPIKE, then a clean run
        run_tick(22, 0, -1, 0, -1, -1, -1, 16);
        check("rst_no_done", done1, -1);
        run_tick(24, 0, -1, 0, -1, -1, -1, -1);
        check("post_rst_done", done1, 20);
        check("post_rst_spikes", spikes, 12);

        // default parameters
        @(negedge clk);
        d_tick = 1'b1;
        @(negedge clk);
        d_tick = 1'b0;
        cnt = 1;
        while (!d_done && cnt < 70000) begin
            @(negedge clk);
            cnt++;
        end
        check("def_done_seen", 32'(d_done), 32'd1);
        check("def_latency", cnt, 66050);
        check("def_axon_idx", 32'(d_axon_idx), 32'd0);
        check("def_neuron_idx", 32'(d_neuron_idx), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
